boolean_propose_scheduler: RTL

- Sequencer for the Boolean proposal datapath of the MCMC constraint solver.
- Holds the current Boolean assignment and picks the variable to flip each iteration.
- Builds the single-bit-flip proposal, presents it to the downstream energy/acceptance evaluator with a valid/done handshake, and commits or discards it.
- Runs a programmed number of iterations, then signals done.

---
 rtl/boolean_propose_scheduler.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/boolean_propose_scheduler.sv
// boolean_propose_scheduler: sequences single-bit-flip Boolean proposals for the MCMC solver.
// Optional macro BOOLEAN_PROPOSE_RANDOM_SELECT_EN selects the flip index from a 16-bit LFSR instead of round-robin.
module boolean_propose_scheduler #(
    parameter int NUM_VARS = 2,
    parameter int IDX_W    = 1,
    parameter int ITER_W   = 16
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                in_start,
    input  logic [NUM_VARS-1:0] in_initial_assignment,
    input  logic [ITER_W-1:0]   in_num_iterations,
    input  logic                in_eval_done,
    input  logic                in_accept,
    output logic                out_proposal_valid,
    output logic [IDX_W-1:0]    out_variable_index,
    output logic [NUM_VARS-1:0] out_current_assignment,
    output logic [NUM_VARS-1:0] out_proposed_assignment,
    output logic [ITER_W-1:0]   out_iteration_count,
    output logic                out_busy,
    output logic                out_done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PROPOSE   = 2'd1,
        ST_WAIT_EVAL = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [NUM_VARS-1:0] current_r;
    logic [NUM_VARS-1:0] current_nxt_s;
    logic [NUM_VARS-1:0] proposed_r;
    logic [NUM_VARS-1:0] proposed_nxt_s;
    logic [IDX_W-1:0]    index_r;
    logic [IDX_W-1:0]    index_nxt_s;
    logic [IDX_W-1:0]    sel_index_s;
    logic [ITER_W-1:0]   count_r;
    logic [ITER_W-1:0]   count_nxt_s;
    logic [ITER_W-1:0]   count_inc_s;
    logic [ITER_W-1:0]   num_iter_r;
    logic [ITER_W-1:0]   num_iter_nxt_s;
    logic                last_iter_s;
    logic                valid_r;
    logic                valid_nxt_s;
    logic                busy_r;
    logic                busy_nxt_s;
    logic                done_r;
    logic                done_nxt_s;

    function automatic logic [NUM_VARS-1:0] flip_bit(input logic [NUM_VARS-1:0] vec,
                                                     input logic [IDX_W-1:0]    idx);
        logic [NUM_VARS-1:0] mask;
        mask = NUM_VARS'(1'b1) << idx;
        return vec ^ mask;
    endfunction

`ifdef BOOLEAN_PROPOSE_RANDOM_SELECT_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign sel_index_s = IDX_W'(lfsr_r % 16'(NUM_VARS));
`else
    function automatic logic [IDX_W-1:0] next_rr_index(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(NUM_VARS - 1)) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    assign sel_index_s = index_r;
`endif

    // The run ends when the iteration about to complete is the N-th one.
    assign count_inc_s = count_r + ITER_W'(1);
    assign last_iter_s = (count_inc_s == num_iter_r);

    // State register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_start) begin
                    if (in_num_iterations != {ITER_W{1'b0}}) begin
                        state_nxt_s = ST_PROPOSE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PROPOSE: begin
                state_nxt_s = ST_WAIT_EVAL;
            end
            ST_WAIT_EVAL: begin
                if (in_eval_done) begin
                    if (last_iter_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_PROPOSE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_EVAL;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        current_nxt_s  = current_r;
        proposed_nxt_s = proposed_r;
        index_nxt_s    = index_r;
        count_nxt_s    = count_r;
        num_iter_nxt_s = num_iter_r;
        valid_nxt_s    = valid_r;
`ifdef BOOLEAN_PROPOSE_RANDOM_SELECT_EN
        lfsr_nxt_s     = lfsr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (in_start) begin
                    current_nxt_s  = in_initial_assignment;
                    num_iter_nxt_s = in_num_iterations;
                    count_nxt_s    = {ITER_W{1'b0}};
                    index_nxt_s    = {IDX_W{1'b0}};
                    valid_nxt_s    = 1'b0;
`ifdef BOOLEAN_PROPOSE_RANDOM_SELECT_EN
                    lfsr_nxt_s     = LFSR_SEED;
`endif
                end else begin
                    valid_nxt_s    = 1'b0;
                end
            end
            ST_PROPOSE: begin
                index_nxt_s    = sel_index_s;
                proposed_nxt_s = flip_bit(current_r, sel_index_s);
                valid_nxt_s    = 1'b1;
`ifdef BOOLEAN_PROPOSE_RANDOM_SELECT_EN
                lfsr_nxt_s     = lfsr_step(lfsr_r);
`endif
            end
            ST_WAIT_EVAL: begin
                if (in_eval_done) begin
                    if (in_accept) begin
                        current_nxt_s = proposed_r;
                    end else begin
                        current_nxt_s = current_r;
                    end
                    count_nxt_s = count_inc_s;
                    valid_nxt_s = 1'b0;
`ifndef BOOLEAN_PROPOSE_RANDOM_SELECT_EN
                    index_nxt_s = next_rr_index(index_r);
`endif
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            ST_DONE: begin
                valid_nxt_s = 1'b0;
            end
            default: begin
                valid_nxt_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            current_r  <= {NUM_VARS{1'b0}};
            proposed_r <= {NUM_VARS{1'b0}};
            index_r    <= {IDX_W{1'b0}};
            count_r    <= {ITER_W{1'b0}};
            num_iter_r <= {ITER_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            current_r  <= current_nxt_s;
            proposed_r <= proposed_nxt_s;
            index_r    <= index_nxt_s;
            count_r    <= count_nxt_s;
            num_iter_r <= num_iter_nxt_s;
            valid_r    <= valid_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

`ifdef BOOLEAN_PROPOSE_RANDOM_SELECT_EN
    // Selection LFSR
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end
`endif

    assign out_proposal_valid      = valid_r;
    assign out_variable_index      = index_r;
    assign out_current_assignment  = current_r;
    assign out_proposed_assignment = proposed_r;
    assign out_iteration_count     = count_r;
    assign out_busy                = busy_r;
    assign out_done                = done_r;

endmodule
